// File: rtl/calc_pkg.sv
// Shared definitions for the calculator entry controller.
// Key codes, operator encoding and FSM state type.
package calc_pkg;

  localparam logic [4:0] KEY_ADD = 5'h10;
  localparam logic [4:0] KEY_MUL = 5'h11;
  localparam logic [4:0] KEY_AND = 5'h12;
  localparam logic [4:0] KEY_EXE = 5'h13;
  localparam logic [4:0] KEY_SUB = 5'h14;
  localparam logic [4:0] KEY_OR  = 5'h15;
  localparam logic [4:0] KEY_CE  = 5'h16;
  localparam logic [4:0] KEY_CLR = 5'h17;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_AND = 3'd3,
    OP_OR  = 3'd4
  } op_t;

  typedef enum logic [1:0] {
    S_A, S_B, S_EXEC, S_RES
  } state_t;

  function automatic logic key_is_op(
    input logic [4:0] k
  );
    return k inside {KEY_ADD, KEY_MUL, KEY_AND,
                     KEY_SUB, KEY_OR};
  endfunction

  function automatic op_t key_to_op(
    input logic [4:0] k
  );
    op_t o;
    case (k)
      KEY_SUB: o = OP_SUB;
      KEY_MUL: o = OP_MUL;
      KEY_AND: o = OP_AND;
      KEY_OR:  o = OP_OR;
      default: o = OP_ADD;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/calc_entry_ctrl_if.sv
// Key-entry / ALU / display bundle of the calculator controller.
// slave: controller side; master: cursor + ALU + display side.
interface calc_entry_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             key_valid;
  logic [4:0]       key_val;
  logic             dec_mode;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [2:0]       op_code;
  logic             exe;
  logic [WIDTH-1:0] display;
  logic             restriction;

  modport slave (
    input  key_valid, key_val, dec_mode, result,
    output op_a, op_b, op_code, exe,
    output display, restriction
  );

  modport master (
    output key_valid, key_val, dec_mode, result,
    input  op_a, op_b, op_code, exe,
    input  display, restriction
  );
endinterface

// File: rtl/entry_accum.sv
// One operand register: digit append (hex or decimal), count, clear, load.
// Ports: dec_mode/digit/append/clear/load_val/load in; value/empty out.
module entry_accum #(
  parameter int WIDTH      = 16,
  parameter int MAX_DIGITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dec_mode,
  input  logic [3:0]       digit,
  input  logic             append,
  input  logic             clear,
  input  logic [WIDTH-1:0] load_val,
  input  logic             load,
  output logic [WIDTH-1:0] value,
  output logic             empty
);

  localparam int CW = $clog2(MAX_DIGITS + 1);

  logic [CW-1:0]    cnt;
  logic             full;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] app_val;

  assign full  = (cnt == CW'(MAX_DIGITS));
  assign empty = (cnt == '0);

  // clear together with append restarts the operand at this digit
  assign base = clear ? '0 : value;

  always_comb begin
    if (dec_mode)
      app_val = base * WIDTH'(10) + WIDTH'(digit);
    else
      app_val = {base[WIDTH-5:0], digit};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
      cnt   <= '0;
    end else if (load) begin
      value <= load_val;
      cnt   <= CW'(MAX_DIGITS);
    end else if (append && (clear || !full)) begin
      value <= app_val;
      cnt   <= clear ? CW'(1) : cnt + CW'(1);
    end else if (clear) begin
      value <= '0;
      cnt   <= '0;
    end
  end

endmodule

// File: rtl/calc_entry_ctrl.sv
// Calculator entry FSM: builds A/op/B from keys, strobes exe, holds result.
// Ports: clk, rst, bus (slave: keys, result in; operands, exe, display out).
module calc_entry_ctrl
  import calc_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int MAX_DIGITS = 4
) (
  input logic             clk,
  input logic             rst,
  calc_entry_ctrl_if.slave bus
);

  state_t           state, state_nx;
  op_t              op_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] a_val, b_val;
  logic             a_empty, b_empty;

  logic is_dig, is_op, is_exe, is_ce, is_clr;
  logic a_app, a_clr, a_ld;
  logic b_app, b_clr;
  logic op_ld, res_ld, all_clr;

  // digits A-F do not exist in decimal entry
  assign is_dig = bus.key_valid && !bus.key_val[4]
               && !(bus.dec_mode && bus.key_val[3:0] > 4'd9);
  assign is_op  = bus.key_valid && key_is_op(bus.key_val);
  assign is_exe = bus.key_valid && bus.key_val == KEY_EXE;
  assign is_ce  = bus.key_valid && bus.key_val == KEY_CE;
  assign is_clr = bus.key_valid && bus.key_val == KEY_CLR;

  always_comb begin
    state_nx = state;
    a_app    = 1'b0;
    a_clr    = 1'b0;
    a_ld     = 1'b0;
    b_app    = 1'b0;
    b_clr    = 1'b0;
    op_ld    = 1'b0;
    res_ld   = 1'b0;
    all_clr  = 1'b0;
    unique case (state)
      S_A: begin
        unique case (1'b1)
          is_dig: a_app = 1'b1;
          is_op: begin
            op_ld    = 1'b1;
            b_clr    = 1'b1;
            state_nx = S_B;
          end
          is_ce:   a_clr = !a_empty;
          is_clr:  all_clr = 1'b1;
          default: ;
        endcase
      end
      S_B: begin
        unique case (1'b1)
          is_dig: b_app = 1'b1;
          is_op:  op_ld = b_empty;
          is_exe: if (!b_empty) state_nx = S_EXEC;
          is_ce:  b_clr = 1'b1;
          is_clr: all_clr = 1'b1;
          default: ;
        endcase
      end
      S_EXEC: begin
        res_ld   = 1'b1;
        state_nx = S_RES;
      end
      S_RES: begin
        unique case (1'b1)
          is_dig: begin
            a_clr    = 1'b1;
            a_app    = 1'b1;
            b_clr    = 1'b1;
            state_nx = S_A;
          end
          // a chained result is loaded as a full operand
          is_op: begin
            a_ld     = 1'b1;
            op_ld    = 1'b1;
            b_clr    = 1'b1;
            state_nx = S_B;
          end
          is_ce, is_clr: all_clr = 1'b1;
          default: ;
        endcase
      end
      default: state_nx = S_A;
    endcase
    if (all_clr) begin
      a_clr    = 1'b1;
      b_clr    = 1'b1;
      state_nx = S_A;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_A;
      op_q  <= OP_ADD;
      res_q <= '0;
    end else begin
      state <= state_nx;
      if (all_clr)     op_q <= OP_ADD;
      else if (op_ld)  op_q <= key_to_op(bus.key_val);
      if (all_clr)     res_q <= '0;
      else if (res_ld) res_q <= bus.result;
    end
  end

  entry_accum #(
    .WIDTH(WIDTH), .MAX_DIGITS(MAX_DIGITS)
  ) u_acc_a (
    .clk(clk), .rst(rst),
    .dec_mode(bus.dec_mode),
    .digit(bus.key_val[3:0]),
    .append(a_app), .clear(a_clr),
    .load_val(res_q), .load(a_ld),
    .value(a_val), .empty(a_empty)
  );

  entry_accum #(
    .WIDTH(WIDTH), .MAX_DIGITS(MAX_DIGITS)
  ) u_acc_b (
    .clk(clk), .rst(rst),
    .dec_mode(bus.dec_mode),
    .digit(bus.key_val[3:0]),
    .append(b_app), .clear(b_clr),
    .load_val('0), .load(1'b0),
    .value(b_val), .empty(b_empty)
  );

  assign bus.op_a        = a_val;
  assign bus.op_b        = b_val;
  assign bus.op_code     = op_q;
  assign bus.exe         = (state == S_EXEC);
  assign bus.restriction = bus.dec_mode;

  always_comb begin
    bus.display = a_val;
    unique case (state)
      S_A:     bus.display = a_val;
      S_B:     bus.display = b_empty ? a_val : b_val;
      S_EXEC:  bus.display = b_val;
      S_RES:   bus.display = res_q;
      default: bus.display = a_val;
    endcase
  end

endmodule
